led_status_mux: RTL
===================

Name: led_status_mux

Overview:
Registered, multi-channel successor to the combinational LED selector on the ALU board. It selects one of CHANNELS WIDTH-bit ALU result buses, each with its own overflow flag, and drives the LED bank and an overflow LED. Adds:
- manual or auto-scan channel selection
- capture/hold of the displayed value
- explicit out-of-range select handling (replaces X output)
- optional overflow blink

Parameters:
WIDTH, 4, bits per channel and LED bank width
CHANNELS, 4, number of input channels (>=2)
SEL_W, 2, select/pointer width; must satisfy 2**SEL_W >= CHANNELS
DWELL, 8, cycles each channel is shown in auto-scan (>=1)
BLINK_DIV, 4, cycles per blink half-period (>=1)

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  reset, asynchronous, active-low
ChanIn  input  CHANNELS*WIDTH  packed results; channel k at [k*WIDTH +: WIDTH]
FlagIn  input  CHANNELS  per-channel overflow flag; bit k belongs to channel k
Sel  input  SEL_W  manual channel select
AutoScan  input  1  1 = rotate channels automatically; 0 = use Sel
Capture  input  1  single-cycle strobe; toggles LIVE/HELD
Out  output  WIDTH  LED bank value
OutFlag  output  1  overflow LED
ActiveChan  output  SEL_W  current channel pointer
Valid  output  1  1 = Out shows a legal channel

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are Clk and Rst_n.
- Reset (Rst_n=0, takes effect immediately, including mid-operation):
  - ActiveChan=0, Out=0, OutFlag=0, Valid=0
  - state=LIVE, dwell counter=0, blink counter=0, blink phase=0, SelBad=0
- Pointer stage (every edge), manual mode (AutoScan=0):
  - If Sel<CHANNELS: ActiveChan<=Sel, SelBad<=0.
  - Otherwise: ActiveChan holds, SelBad<=1.
- Pointer stage, auto-scan (AutoScan=1):
  - SelBad<=0.
  - Dwell counter counts 0..DWELL-1.
  - On DWELL-1: ActiveChan<=ActiveChan+1, wrapping CHANNELS-1 -> 0; counter<=0.
  - Dwell counter is cleared whenever AutoScan=0, so scanning resumes from the current ActiveChan with a full dwell.
  - AutoScan 1->0: next edge loads Sel.
- Display stage, state LIVE:
  - DispReg<=ChanIn[ActiveChan] and FlagReg<=FlagIn[ActiveChan].
  - If SelBad=1, both load 0 instead.
  - Valid<=~SelBad.
  - Latency: Sel to ActiveChan = 1 edge; Sel to Out/OutFlag/Valid = 2 edges.
- Display stage, state HELD:
  - DispReg, FlagReg and Valid are frozen.
  - The pointer stage keeps running.
- Capture:
  - In LIVE: the normal load occurs on that edge, then state<=HELD.
  - In HELD: state<=LIVE; the next edge reloads.
  - Capture held high toggles state every cycle; no edge detection is required.
- Outputs are driven from registers only (no combinational path from inputs):
  - Out=DispReg, OutFlag=FlagReg, subject to the optional feature below.

Optional Feature:
Macro LED_STATUS_BLINK_EN.
- Defined:
  - Blink counter runs freely 0..BLINK_DIV-1; on wrap, blink phase toggles.
  - When FlagReg=1 and phase=1, Out=0; otherwise Out=DispReg.
  - OutFlag follows the same gating (FlagReg & ~phase).
  - Blink runs in both LIVE and HELD.
- Undefined: no blink counter is instantiated; Out=DispReg and OutFlag=FlagReg steadily.

Test Plan:
Configuration for all scenarios: WIDTH=4, CHANNELS=3, SEL_W=2, DWELL=4, BLINK_DIV=2. Channel inputs: ch0=4'h3, ch1=4'hA, ch2=4'h5. FlagIn=0 unless stated.
1. Reset: drive Sel=1, run 5 cycles, then pull Rst_n low between edges -> Out, OutFlag, Valid, ActiveChan read 0 before the next edge.
2. Manual select: Sel=1 after reset -> ActiveChan=1 after edge 1; Out=4'hA and Valid=1 after edge 2. Then Sel=2 -> Out=4'h5 two edges later.
3. Out-of-range select: Sel=3 -> ActiveChan holds 2; Out=0 and Valid=0 after 2 edges. Then Sel=0 -> Valid=1 and Out=4'h3 after 2 edges.
4. Auto-scan: AutoScan=1 with ActiveChan=1 -> ActiveChan goes 1,2,0,1, changing every 4 edges; Out tracks one edge behind.
5. Capture: LIVE with Out=4'hA; pulse Capture, then change ch1 to 4'hF -> Out stays 4'hA and ActiveChan still tracks Sel. Second pulse -> Out=4'hF one edge later.
6. Blink: FlagIn[1]=1, Sel=1.
   - With LED_STATUS_BLINK_EN: Out alternates 4'hA/0 every 2 cycles, OutFlag toggles in step.
   - Without the macro: Out=4'hA and OutFlag=1 steady.

Source files
------------

// File: rtl/led_status_mux.sv
// Registered LED selector: manual/auto-scan channel pointer, capture/hold of the
// displayed value, out-of-range select blanking. Optional blink via LED_STATUS_BLINK_EN.
module led_status_mux #(
  parameter int WIDTH     = 4,
  parameter int CHANNELS  = 4,
  parameter int SEL_W     = 2,
  parameter int DWELL     = 8,
  parameter int BLINK_DIV = 4
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [CHANNELS*WIDTH-1:0] ChanIn,
  input  logic [CHANNELS-1:0]       FlagIn,
  input  logic [SEL_W-1:0]          Sel,
  input  logic                      AutoScan,
  input  logic                      Capture,
  output logic [WIDTH-1:0]          Out,
  output logic                      OutFlag,
  output logic [SEL_W-1:0]          ActiveChan,
  output logic                      Valid
);

  localparam int SLOTS = 1 << SEL_W;
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W:0]   CH_LIM  = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);

  if (CHANNELS < 2 || SLOTS < CHANNELS || DWELL < 1 || BLINK_DIV < 1) begin : g_bad_param
    $error("led_status_mux: illegal parameter combination");
  end

  typedef enum logic {LIVE, HELD} state_t;

  state_t            state;
  logic [WIDTH-1:0]  chan [SLOTS];
  logic [SLOTS-1:0]  flag_vec;
  logic [DW_W-1:0]   dwell_cnt;
  logic              sel_bad;
  logic [WIDTH-1:0]  disp_reg;
  logic              flag_reg;

  // Unused pointer codes map to zero so every index of the mux is defined.
  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    if (k < CHANNELS) begin : g_used
      assign chan[k]     = ChanIn[k*WIDTH +: WIDTH];
      assign flag_vec[k] = FlagIn[k];
    end else begin : g_unused
      assign chan[k]     = '0;
      assign flag_vec[k] = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ActiveChan <= '0;
      sel_bad    <= 1'b0;
      dwell_cnt  <= '0;
    end else if (!AutoScan) begin
      dwell_cnt <= '0;
      if ({1'b0, Sel} < CH_LIM) begin
        ActiveChan <= Sel;
        sel_bad    <= 1'b0;
      end else begin
        sel_bad    <= 1'b1;
      end
    end else begin
      sel_bad <= 1'b0;
      if (dwell_cnt == DW_LAST) begin
        dwell_cnt  <= '0;
        ActiveChan <= (ActiveChan == CH_LAST) ? '0 : ActiveChan + 1'b1;
      end else begin
        dwell_cnt  <= dwell_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= LIVE;
      disp_reg <= '0;
      flag_reg <= 1'b0;
      Valid    <= 1'b0;
    end else begin
      case (state)
        LIVE: begin
          disp_reg <= sel_bad ? '0 : chan[ActiveChan];
          flag_reg <= sel_bad ? 1'b0 : flag_vec[ActiveChan];
          Valid    <= ~sel_bad;
          if (Capture) state <= HELD;
        end
        HELD: begin
          if (Capture) state <= LIVE;
        end
        default: state <= LIVE;
      endcase
    end
  end

`ifdef LED_STATUS_BLINK_EN
  localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);

  logic [BL_W-1:0] blink_cnt;
  logic            blink_phase;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BL_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  assign Out     = (flag_reg & blink_phase) ? '0 : disp_reg;
  assign OutFlag = flag_reg & ~blink_phase;
`else
  assign Out     = disp_reg;
  assign OutFlag = flag_reg;
`endif

endmodule
